design_switch_ctrl: RTL

DESIGN_SWITCH_CTRL -- requirements
Module: design_switch_ctrl

---
 rtl/design_switch_pkg.sv | 25 ++
 rtl/design_switch_ctrl_timer.sv | 27 ++
 rtl/design_switch_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/design_switch_pkg.sv
// Shared types and constants for the design-select controller.
package design_switch_pkg;

  localparam int NUM_DESIGNS = 12;
  localparam int SEL_W       = 4;
  localparam int CNT_W       = 8;

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_DESIGNS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN,
    ST_RESET_HOLD
  } state_t;

  // Active-low chip-select pattern for a design number; 0 selects nothing.
  function automatic logic [NUM_DESIGNS-1:0] ncs_for(input logic [SEL_W-1:0] sel);
    logic [NUM_DESIGNS-1:0] ncs;
    ncs = '1;
    if (sel != '0 && sel <= MAX_SEL) ncs[sel - 1'b1] = 1'b0;
    return ncs;
  endfunction

endpackage

// File: rtl/design_switch_ctrl_timer.sv
// Shared settle/reset down-counter: loads N-1, counts down, holds at zero.
module switch_timer
  import design_switch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // Load takes priority; otherwise decrement and stick at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/design_switch_ctrl.sv
// Design-select controller: safely drains the pads, holds the new target in
// reset, then enables its chip select and releases the pads.
module design_switch_ctrl
  import design_switch_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int RESET_CYCLES  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SEL_W-1:0]       sel_req,
  input  logic                   sel_valid,
  output logic                   sel_ready,
  output logic [SEL_W-1:0]       active_sel,
  output logic [NUM_DESIGNS-1:0] design_ncs,
  output logic                   gpio_safe,
  output logic                   switch_done,
  output logic                   sel_err
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LOAD  = CNT_W'(RESET_CYCLES - 1);

  state_t           state;
  logic [SEL_W-1:0] target;
  logic             expired;
  logic             accept;
  logic             req_bad;
  logic [SEL_W-1:0] req_eff;
  logic             start_switch;
  logic             enter_hold;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;

  // Ready comes straight from the registered state so it never depends on sel_valid.
  assign sel_ready    = (state == ST_IDLE) || (state == ST_ACTIVE);
  assign accept       = sel_valid && sel_ready;
  assign req_bad      = (sel_req > MAX_SEL);
  assign req_eff      = req_bad ? '0 : sel_req;
  assign start_switch = accept && (req_eff != active_sel);
  assign enter_hold   = (state == ST_DRAIN) && expired && (target != '0);

  // Timer is reloaded on entry to DRAIN and to RESET_HOLD.
  always_comb begin
    timer_load = start_switch || enter_hold;
    timer_val  = start_switch ? SETTLE_LOAD : RESET_LOAD;
  end

  switch_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (expired)
  );

  // Switch sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      target      <= '0;
      active_sel  <= '0;
      design_ncs  <= '1;
      gpio_safe   <= 1'b1;
      switch_done <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      switch_done <= 1'b0;
      if (accept && req_bad) sel_err <= 1'b1;
      case (state)
        ST_IDLE, ST_ACTIVE: begin
          if (start_switch) begin
            target     <= req_eff;
            design_ncs <= '1;
            gpio_safe  <= 1'b1;
            state      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (expired) begin
            if (target == '0) begin
              state       <= ST_IDLE;
              active_sel  <= '0;
              switch_done <= 1'b1;
            end else begin
              state      <= ST_RESET_HOLD;
              active_sel <= target;
            end
          end
        end
        ST_RESET_HOLD: begin
          if (expired) begin
            state       <= ST_ACTIVE;
            design_ncs  <= ncs_for(target);
            gpio_safe   <= 1'b0;
            switch_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
